// File: rtl/inta_sequencer.sv
// rtl/inta_sequencer.sv - CPU-side INT/INTA handshake sequencer with vector capture
//
// Detects a synchronized, enabled interrupt request and drives the two-pulse
// active-low INTA sequence to the PIC. The PIC's vector is captured on the edge
// that ends the second pulse and offered to the CPU over a valid/ack handshake.
//
// Ports:
//   i_clk        single clock, all state changes on posedge
//   i_rst        synchronous active-high reset
//   i_int        interrupt request from the PIC (asynchronous level)
//   i_ie         CPU interrupt enable; gates only the start of a new sequence
//   i_d_in[7:0]  PIC data bus, sampled at the end of the second pulse
//   i_vec_ack    CPU consumed the vector; ignored unless o_vec_valid is high
//   o_inta_n     interrupt acknowledge to the PIC, active low, registered
//   o_vec[7:0]   captured vector, stable while o_vec_valid is high
//   o_vec_valid  vector available to the CPU, registered
//   o_busy       high whenever a sequence is in progress (state != IDLE)

module inta_sequencer #(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_int,
    input  logic       i_ie,
    input  logic [7:0] i_d_in,
    input  logic       i_vec_ack,
    output logic       o_inta_n,
    output logic [7:0] o_vec,
    output logic       o_vec_valid,
    output logic       o_busy
);

    localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CW    = $clog2(MAX_W) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_P1    = 3'd1,
        S_GAP   = 3'd2,
        S_P2    = 3'd3,
        S_VALID = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_sync1;
    logic            r_int_s;
    logic            r_inta_n;
    logic            r_vec_valid;
    logic [7:0]      r_vec;

    logic            w_last_pulse;
    logic            w_last_gap;
    logic            w_inta_n_nxt;
    logic            w_vec_valid_nxt;
    logic            w_capture;
    logic            w_timed;

    assign w_last_pulse = (r_cnt == CW'(PULSE_W - 1));
    assign w_last_gap   = (r_cnt == CW'(GAP_W - 1));

    // State register plus the registered outputs, which are computed from the
    // next state so INTA_N and VEC_VALID change on the same edge as the state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sync1     <= 1'b0;
            r_int_s     <= 1'b0;
            r_inta_n    <= 1'b1;
            r_vec_valid <= 1'b0;
            r_vec       <= 8'h00;
        end else begin
            r_sync1     <= i_int;
            r_int_s     <= r_sync1;
            r_state     <= w_next;
            r_inta_n    <= w_inta_n_nxt;
            r_vec_valid <= w_vec_valid_nxt;
            // Counter restarts on every state change and only runs in timed states.
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_timed) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_capture) begin
                r_vec <= i_d_in;
            end
        end
    end

    // Next-state logic. Once P1 is entered the sequence runs to completion
    // regardless of INT or IE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (r_int_s && i_ie) w_next = S_P1;
            S_P1:    if (w_last_pulse)    w_next = S_GAP;
            S_GAP:   if (w_last_gap)      w_next = S_P2;
            S_P2:    if (w_last_pulse)    w_next = S_VALID;
            S_VALID: if (i_vec_ack)       w_next = S_IDLE;
            default:                      w_next = S_IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        w_inta_n_nxt    = 1'b1;
        w_vec_valid_nxt = 1'b0;
        w_capture       = 1'b0;
        w_timed         = 1'b0;
        if (w_next == S_P1 || w_next == S_P2) w_inta_n_nxt = 1'b0;
        if (w_next == S_VALID)                w_vec_valid_nxt = 1'b1;
        if (r_state == S_P2 && w_next == S_VALID) w_capture = 1'b1;
        if (r_state == S_P1 || r_state == S_GAP || r_state == S_P2) w_timed = 1'b1;
    end

    assign o_inta_n    = r_inta_n;
    assign o_vec_valid = r_vec_valid;
    assign o_vec       = r_vec;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_inta_sequencer.sv
// tb/tb_inta_sequencer.sv - self-checking bench for inta_sequencer (two parameter sets)

module tb_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       int_in;
    logic       ie;
    logic [7:0] d_in;
    logic       ack;

    logic       inta_n [2];
    logic [7:0] vec    [2];
    logic       valid  [2];
    logic       busy   [2];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    inta_sequencer #(.PULSE_W(2), .GAP_W(2)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_int(int_in), .i_ie(ie), .i_d_in(d_in),
        .i_vec_ack(ack), .o_inta_n(inta_n[0]), .o_vec(vec[0]),
        .o_vec_valid(valid[0]), .o_busy(busy[0])
    );

    inta_sequencer #(.PULSE_W(1), .GAP_W(3)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_int(int_in), .i_ie(ie), .i_d_in(d_in),
        .i_vec_ack(ack), .o_inta_n(inta_n[1]), .o_vec(vec[1]),
        .o_vec_valid(valid[1]), .o_busy(busy[1])
    );

    // Reference model: a sequence is described by the number of edges since it
    // started; pulse/gap windows and the capture point follow from arithmetic.
    bit       m_s1    [2];
    bit       m_s2    [2];
    bit       m_busy  [2];
    bit       m_valid [2];
    int       m_rel   [2];
    logic [7:0] m_vec [2];

    function automatic int pw(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int gw(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int exp_inta(input int i);
        if (m_busy[i] && !m_valid[i] && !(m_rel[i] >= pw(i) && m_rel[i] < pw(i) + gw(i)))
            return 0;
        return 1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_busy[i] = 1'b0;
                m_valid[i] = 1'b0; m_rel[i] = 0; m_vec[i] = 8'h00;
            end else begin
                if (!m_busy[i]) begin
                    if (m_s2[i] && ie) begin
                        m_busy[i] = 1'b1;
                        m_rel[i]  = 0;
                    end
                end else if (m_valid[i]) begin
                    if (ack) begin
                        m_busy[i]  = 1'b0;
                        m_valid[i] = 1'b0;
                    end
                end else begin
                    m_rel[i] = m_rel[i] + 1;
                    if (m_rel[i] == 2 * pw(i) + gw(i)) begin
                        m_valid[i] = 1'b1;
                        m_vec[i]   = d_in;
                    end
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = int_in;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("model_inta_n%0d", i), int'(inta_n[i]), exp_inta(i));
                chk($sformatf("model_busy%0d", i), int'(busy[i]), int'(m_busy[i]));
                chk($sformatf("model_valid%0d", i), int'(valid[i]), int'(m_valid[i]));
                chk($sformatf("model_vec%0d", i), int'(vec[i]), int'(m_vec[i]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        bit seen;
        rst = 1'b1; int_in = 1'b0; ie = 1'b0; d_in = 8'h00; ack = 1'b0;
        tick();
        chk_en = 1'b1;
        tick(); tick();
        chk("rst_inta_n", int'(inta_n[0]), 1);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_valid", int'(valid[0]), 0);
        chk("rst_vec", int'(vec[0]), 8'h00);
        rst = 1'b0;
        tick();

        // Basic sequence; INT first sampled at edge k
        ie = 1'b1; d_in = 8'h48; int_in = 1'b1;
        tick();                                            // k
        tick(); chk("t1_k1_inta0", int'(inta_n[0]), 1);    // k+1
        tick(); chk("t1_k2_inta0", int'(inta_n[0]), 0);    // k+2
        chk("t1_k2_inta1", int'(inta_n[1]), 0);
        int_in = 1'b0;
        tick(); chk("t1_k3_inta0", int'(inta_n[0]), 0);    // k+3
        chk("t1_k3_inta1", int'(inta_n[1]), 1);
        tick(); chk("t1_k4_inta0", int'(inta_n[0]), 1);    // k+4
        ack = 1'b1;
        tick(); ack = 1'b0;                                // k+5, early ack ignored
        chk("t1_k5_inta1", int'(inta_n[1]), 1);
        chk("t1_k5_busy0", int'(busy[0]), 1);
        tick(); chk("t1_k6_inta0", int'(inta_n[0]), 0);    // k+6
        chk("t1_k6_inta1", int'(inta_n[1]), 0);
        tick(); chk("t1_k7_inta0", int'(inta_n[0]), 0);    // k+7
        chk("t1_k7_valid1", int'(valid[1]), 1);
        chk("t1_k7_vec1", int'(vec[1]), 8'h48);
        chk("t1_k7_valid0", int'(valid[0]), 0);
        tick();                                            // k+8
        chk("t1_k8_inta0", int'(inta_n[0]), 1);
        chk("t1_k8_valid0", int'(valid[0]), 1);
        chk("t1_k8_vec0", int'(vec[0]), 8'h48);
        tick(); ack = 1'b1;                                // k+9
        tick(); ack = 1'b0;                                // k+10
        chk("t1_ack_valid0", int'(valid[0]), 0);
        chk("t1_ack_busy0", int'(busy[0]), 0);
        chk("t1_ack_vec0", int'(vec[0]), 8'h48);

        // Spurious: glitch never sampled by a clock edge
        repeat (3) tick();
        int_in = 1'b1; #1 int_in = 1'b0;
        repeat (8) begin
            tick();
            chk("t2_busy0", int'(busy[0]), 0);
            chk("t2_inta0", int'(inta_n[0]), 1);
        end

        // IE gating
        ie = 1'b0; int_in = 1'b1;
        repeat (20) tick();
        chk("t3_gated_busy0", int'(busy[0]), 0);
        chk("t3_gated_busy1", int'(busy[1]), 0);
        ie = 1'b1;
        tick();
        chk("t3_p1_inta0", int'(inta_n[0]), 0);
        chk("t3_p1_busy0", int'(busy[0]), 1);
        int_in = 1'b0;
        tick(); tick();
        chk("t3_gap_inta0", int'(inta_n[0]), 1);
        ie = 1'b0;
        repeat (4) tick();
        chk("t3_done_valid0", int'(valid[0]), 1);

        // Ack withheld while the bus changes
        d_in = 8'hFF;
        repeat (50) tick();
        chk("t4_vec0", int'(vec[0]), 8'h48);
        chk("t4_vec1", int'(vec[1]), 8'h48);
        chk("t4_valid0", int'(valid[0]), 1);
        chk("t4_inta0", int'(inta_n[0]), 1);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("t4_ack_valid0", int'(valid[0]), 0);
        ie = 1'b1; d_in = 8'h48;
        tick();

        // Reset during the last cycle of P2
        int_in = 1'b1;
        tick(); int_in = 1'b0;                             // k
        repeat (6) tick();                                 // k+7
        chk("t5_p2_inta0", int'(inta_n[0]), 0);
        rst = 1'b1;
        tick(); rst = 1'b0;                                // k+8
        chk("t5_rst_inta0", int'(inta_n[0]), 1);
        chk("t5_rst_busy0", int'(busy[0]), 0);
        chk("t5_rst_valid0", int'(valid[0]), 0);
        chk("t5_rst_vec0", int'(vec[0]), 8'h00);
        int_in = 1'b1;
        tick(); int_in = 1'b0;
        repeat (8) tick();
        chk("t5_fresh_valid0", int'(valid[0]), 1);
        chk("t5_fresh_vec0", int'(vec[0]), 8'h48);
        ack = 1'b1; tick(); ack = 1'b0;

        // Back-to-back with INT held and ack held
        int_in = 1'b1; ack = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (valid[0]) seen = 1'b1;
        end
        chk("t6_valid_seen", int'(seen), 1);
        tick();
        chk("t6_idle_valid0", int'(valid[0]), 0);
        chk("t6_idle_busy0", int'(busy[0]), 0);
        chk("t6_idle_inta0", int'(inta_n[0]), 1);
        tick();
        chk("t6_p1_busy0", int'(busy[0]), 1);
        chk("t6_p1_inta0", int'(inta_n[0]), 0);
        int_in = 1'b0; ack = 1'b0;

        // Random traffic, checked by the model every cycle
        repeat (3000) begin
            if ($urandom_range(0, 5) == 0) int_in = ~int_in;
            ie   = ($urandom_range(0, 7) != 0);
            ack  = ($urandom_range(0, 2) == 0);
            d_in = 8'($urandom);
            rst  = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; ack = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
